// File: rtl/memstream_multi_pkg.sv
// Shared constants, lane arithmetic and FSM state types for the multi-channel
// weight streamer.
package memstream_multi_pkg;

  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of 32-bit AXI-Lite lanes needed to cover one memory word.
  function automatic int nfolds(input int width);
    return (width + 31) / 32;
  endfunction

  // Lanes are addressed as a power of two so the word index is a plain shift.
  function automatic int lanes(input int width);
    return 1 << $clog2(nfolds(width));
  endfunction

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_e;

endpackage

// File: rtl/memstream_multi_fifo.sv
// Four-entry output buffer for one stream. Upstream credit tracking keeps
// pushes from ever exceeding the free space, so no full flag is needed.
module memstream_multi_fifo
  import memstream_multi_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] slot_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign empty_o = (count_q == '0);
  assign head_o  = slot_q[rd_ptr_q];

  // Storage is left out of reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      slot_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/memstream_multi.sv
// Multi-channel weight streamer: one AXI-Lite loaded memory replayed cyclically
// by NSTREAMS AXI-Stream outputs. Define MEMSTREAM_MULTI_AXIREAD_EN for readback.
module memstream_multi
  import memstream_multi_pkg::*;
#(
  parameter int                     NSTREAMS    = 2,
  parameter int                     MEM_DEPTH   = 1024,
  parameter int                     MEM_WIDTH   = 32,
  parameter logic [NSTREAMS*32-1:0] STRM_OFFSET = '0,
  parameter logic [NSTREAMS*32-1:0] STRM_DEPTH  = {NSTREAMS{32'd1024}},
  parameter string                  MEM_INIT    = ""
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [31:0]                   awaddr,
  input  logic [2:0]                    awprot,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [31:0]                   wdata,
  input  logic [3:0]                    wstrb,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [1:0]                    bresp,
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [31:0]                   araddr,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [31:0]                   rdata,
  output logic [1:0]                    rresp,
  input  logic [NSTREAMS-1:0]           m_axis_afull,
  input  logic [NSTREAMS-1:0]           m_axis_tready,
  output logic [NSTREAMS-1:0]           m_axis_tvalid,
  output logic [NSTREAMS*MEM_WIDTH-1:0] m_axis_tdata
);

  localparam int NF = nfolds(MEM_WIDTH);
  localparam int NL = lanes(MEM_WIDTH);
  localparam int LB = $clog2(NL);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int SW = (NSTREAMS > 1) ? $clog2(NSTREAMS) : 1;

  // ---------------- AXI-Lite write channel ----------------
  wr_state_e   wr_state_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        wr_fire;
  logic        wr_en;
  logic        aw_ok;
  logic [31:0] aw_word;
  logic [31:0] aw_lane;

  assign aw_word = awaddr >> (2 + LB);
  assign aw_lane = (awaddr >> 2) & 32'(NL - 1);
  assign aw_ok   = (aw_word < 32'(MEM_DEPTH)) && (aw_lane < 32'(NF));

  assign wr_fire = (wr_state_q == WR_IDLE) && awvalid && wvalid;
  assign wr_en   = wr_fire && aw_ok;
  assign awready = wr_fire;
  assign wready  = wr_fire;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        WR_IDLE: if (wr_fire) begin
          wr_state_q <= WR_RESP;
          bvalid_q   <= 1'b1;
          bresp_q    <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        end
        WR_RESP: if (bready) begin
          wr_state_q <= WR_IDLE;
          bvalid_q   <= 1'b0;
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // ---------------- AXI-Lite read channel ----------------
  rd_state_e   rd_state_q;
  logic        rd_wait_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;
  logic        rd_fire;
  logic        ar_use;
  logic [31:0] ar_word;
  logic [31:0] rdata_d;
  logic [1:0]  rresp_d;

  // A read never shares its accept cycle with a write: the write owns the port.
  assign rd_fire = (rd_state_q == RD_IDLE) && arvalid && !wr_fire;
  assign arready = rd_fire;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign ar_word = araddr >> (2 + LB);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_wait_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (rd_fire) begin
          rd_state_q <= RD_WAIT;
          rd_wait_q  <= 1'b0;
        end
        RD_WAIT: if (!rd_wait_q) begin
          rd_wait_q <= 1'b1;
        end else begin
          rd_state_q <= RD_DATA;
          rvalid_q   <= 1'b1;
          rresp_q    <= rresp_d;
          rdata_q    <= rdata_d;
        end
        RD_DATA: if (rready) begin
          rd_state_q <= RD_IDLE;
          rvalid_q   <= 1'b0;
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // ---------------- Memory lanes and read pipeline ----------------
  logic [AW-1:0]        p1_addr_q;
  logic [AW-1:0]        p1_addr_d;
  logic                 p1_vld_q;
  logic [SW-1:0]        p1_sid_q;
  logic                 p2_vld_q;
  logic [SW-1:0]        p2_sid_q;
  logic [MEM_WIDTH-1:0] mem_dout;

`ifdef MEMSTREAM_MULTI_AXIREAD_EN
  logic [31:0] lane_out32 [NF];
`endif

  for (genvar gi = 0; gi < NF; gi++) begin : g_lane
    localparam int LW = (gi == NF - 1) ? (MEM_WIDTH - 32 * gi) : 32;
    logic [LW-1:0] lane_mem [MEM_DEPTH];
    logic [LW-1:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && (aw_lane == 32'(gi))) begin
        lane_mem[aw_word[AW-1:0]] <= wdata[LW-1:0];
      end
      lane_rd_q <= lane_mem[p1_addr_q];
    end

    assign mem_dout[32*gi +: LW] = lane_rd_q;
`ifdef MEMSTREAM_MULTI_AXIREAD_EN
    assign lane_out32[gi] = 32'(lane_rd_q);
`endif
  end

`ifdef MEMSTREAM_MULTI_AXIREAD_EN
  logic [31:0] ar_lane;
  logic        ar_ok;
  logic        ar_err_q;
  logic [31:0] ar_lane_q;

  assign ar_lane = (araddr >> 2) & 32'(NL - 1);
  assign ar_ok   = (ar_word < 32'(MEM_DEPTH)) && (ar_lane < 32'(NF));
  assign ar_use  = rd_fire && ar_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_err_q  <= 1'b0;
      ar_lane_q <= '0;
    end else if (rd_fire) begin
      ar_err_q  <= !ar_ok;
      ar_lane_q <= ar_lane;
    end
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = ar_err_q ? RESP_SLVERR : RESP_OKAY;
    for (int k = 0; k < NF; k++) begin
      if (!ar_err_q && (ar_lane_q == 32'(k))) begin
        rdata_d = lane_out32[k];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{awprot, wstrb, wdata};
`else
  // Without readback the read channel only answers; the memory has one consumer.
  assign ar_use  = 1'b0;
  assign rdata_d = '0;
  assign rresp_d = RESP_SLVERR;

  logic unused_ok;
  assign unused_ok = ^{awprot, wstrb, wdata, ar_word};
`endif

  // ---------------- Stream arbitration ----------------
  logic [NSTREAMS-1:0] req;
  logic [AW-1:0]       strm_addr [NSTREAMS];
  logic [SW-1:0]       rr_q;
  logic [SW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                port_busy;
  int                  cand;

  assign port_busy = wr_fire || ar_use;

  // Search starts one past the last winner; rr_q only moves on a real grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NSTREAMS; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NSTREAMS) begin
        cand = cand - NSTREAMS;
      end
      if (!gnt_any && !port_busy && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(cand);
      end
    end
  end

  always_comb begin
    p1_addr_d = p1_addr_q;
    if (ar_use) begin
      p1_addr_d = ar_word[AW-1:0];
    end else if (gnt_any) begin
      p1_addr_d = strm_addr[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    p1_addr_q <= p1_addr_d;
    if (rst) begin
      rr_q     <= SW'(NSTREAMS - 1);
      p1_vld_q <= 1'b0;
      p1_sid_q <= '0;
      p2_vld_q <= 1'b0;
      p2_sid_q <= '0;
    end else begin
      if (gnt_any) begin
        rr_q <= gnt_idx;
      end
      p1_vld_q <= gnt_any;
      p1_sid_q <= gnt_idx;
      p2_vld_q <= p1_vld_q;
      p2_sid_q <= p1_sid_q;
    end
  end

  // ---------------- Per-stream pointer, credits and buffer ----------------
  for (genvar gi = 0; gi < NSTREAMS; gi++) begin : g_strm
    localparam logic [31:0] OFF = STRM_OFFSET[32*gi +: 32];
    localparam logic [31:0] DEP = STRM_DEPTH[32*gi +: 32];

    logic [31:0] ptr_q;
    logic [2:0]  cred_q;
    logic        gnt_i;
    logic        pop_i;
    logic        push_i;
    logic        empty;
    logic [MEM_WIDTH-1:0] head;

    assign gnt_i  = gnt_any && (gnt_idx == SW'(gi));
    assign pop_i  = m_axis_tvalid[gi] && m_axis_tready[gi];
    assign push_i = p2_vld_q && (p2_sid_q == SW'(gi));
    assign req[gi]       = (cred_q != 3'd0) && !m_axis_afull[gi];
    assign strm_addr[gi] = ptr_q[AW-1:0];

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_q  <= OFF;
        cred_q <= 3'(FIFO_DEPTH);
      end else begin
        if (gnt_i) begin
          ptr_q <= (ptr_q + 32'd1 == OFF + DEP) ? OFF : ptr_q + 32'd1;
        end
        case ({gnt_i, pop_i})
          2'b10:   cred_q <= cred_q - 3'd1;
          2'b01:   cred_q <= cred_q + 3'd1;
          default: cred_q <= cred_q;
        endcase
      end
    end

    memstream_multi_fifo #(.WIDTH(MEM_WIDTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_i),
      .data_i  (mem_dout),
      .pop_i   (pop_i),
      .empty_o (empty),
      .head_o  (head)
    );

    assign m_axis_tvalid[gi] = !empty;
    assign m_axis_tdata[gi*MEM_WIDTH +: MEM_WIDTH] = head;
  end

endmodule

// File: tb/tb_memstream_multi.sv
// Scoreboard bench for memstream_multi: 2 streams of 70-bit words, regions 0/20
// of depth 20, AXI-Lite load/readback, fairness, backpressure and reset checks.
module tb_memstream_multi;
  localparam int NS = 2;
  localparam int MD = 64;
  localparam int MW = 70;
  localparam int NFD = 3;
  localparam int NLN = 4;
  localparam int SDEP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [2:0] awprot = 0;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic [NS-1:0] afull = 0, tready = 0, tvalid;
  logic [NS*MW-1:0] tdata;

  memstream_multi #(
    .NSTREAMS(NS), .MEM_DEPTH(MD), .MEM_WIDTH(MW),
    .STRM_OFFSET({32'd20, 32'd0}), .STRM_DEPTH({32'd20, 32'd20}), .MEM_INIT("")
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .m_axis_afull(afull), .m_axis_tready(tready),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } axi_exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] g [MD][NFD];
  logic [MW-1:0] exp_q0[$];
  logic [MW-1:0] exp_q1[$];
  axi_exp_t bq[$];
  axi_exp_t rq[$];
  int  pop_log[$];
  bit  stream_chk = 0;
  bit  log_en = 0;
  int  beats0 = 0, beats1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [MW-1:0] word_of(input int w);
    return {g[w][2][5:0], g[w][1], g[w][0]};
  endfunction

  // Expected stream contents follow directly from the region definition.
  task automatic load_expected();
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < 600; k++) begin
      exp_q0.push_back(word_of(0 + (k % SDEP)));
      exp_q1.push_back(word_of(20 + (k % SDEP)));
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    axi_exp_t e;
    if (stream_chk && tvalid[0] && tready[0]) begin
      beats0++;
      if (log_en) pop_log.push_back(0);
      if (exp_q0.size() == 0) check("s0_underflow", 1, 0);
      else check("s0_data", tdata[0 +: MW], exp_q0.pop_front());
    end
    if (stream_chk && tvalid[1] && tready[1]) begin
      beats1++;
      if (log_en) pop_log.push_back(1);
      if (exp_q1.size() == 0) check("s1_underflow", 1, 0);
      else check("s1_data", tdata[MW +: MW], exp_q1.pop_front());
    end
    if (bvalid && bready) begin
      if (bq.size() == 0) check("b_unexpected", 1, 0);
      else begin
        e = bq.pop_front();
        $display("axi write done: bresp=%0d cycle=%0d", bresp, cyc);
        check("bresp", bresp, e.resp);
        check("b_latency", cyc, e.cyc);
      end
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) check("r_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        $display("axi read done: rresp=%0d rdata=%h cycle=%0d", rresp, rdata, cyc);
        check("rresp", rresp, e.resp);
        check("rdata", rdata, e.data);
        check("r_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input int word, input int lane, input logic [31:0] d);
    axi_exp_t e;
    bit ok;
    int t;
    ok = (word < MD) && (lane < NFD);
    awaddr = 32'((word * NLN + lane) * 4) | 32'($urandom_range(0, 3));
    wdata = d;
    awprot = 3'($urandom);
    wstrb = 4'($urandom);
    awvalid = 1;
    wvalid = 1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (awready && wready) break;
      t++;
      if (t > 20) break;
    end
    if (!(awready && wready)) check("aw_timeout", 1, 0);
    else begin
      e.resp = ok ? 2'b00 : 2'b10;
      e.data = '0;
      e.cyc = cyc + 1;
      bq.push_back(e);
      if (ok) g[word][lane] = d;
    end
    @(posedge clk);
    #1;
    awvalid = 0;
    wvalid = 0;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (bvalid) break;
      t++;
      if (t > 20) break;
    end
    if (!bvalid) check("b_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input int word, input int lane);
    axi_exp_t e;
    bit ok;
    int t;
    ok = (word < MD) && (lane < NFD);
    araddr = 32'((word * NLN + lane) * 4) | 32'($urandom_range(0, 3));
    arvalid = 1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (arready) break;
      t++;
      if (t > 20) break;
    end
    if (!arready) check("ar_timeout", 1, 0);
    else begin
`ifdef MEMSTREAM_MULTI_AXIREAD_EN
      e.resp = ok ? 2'b00 : 2'b10;
      e.data = !ok ? 32'd0 : (lane == 2) ? {26'd0, g[word][2][5:0]} : g[word][lane];
`else
      e.resp = 2'b10;
      e.data = 32'd0;
`endif
      e.cyc = cyc + 3;
      rq.push_back(e);
    end
    @(posedge clk);
    #1;
    arvalid = 0;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (rvalid) break;
      t++;
      if (t > 20) break;
    end
    if (!rvalid) check("r_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first0, first1, b0, b1, reps;
    for (int w = 0; w < MD; w++)
      for (int l = 0; l < NFD; l++) g[w][l] = '0;

    // Reset values
    tick(2);
    @(negedge clk);
    check("rst_ready_valid", {awready, wready, bvalid, arready, rvalid, tvalid}, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk);
    #1;
    rst = 0;

    // Load 40 words lane by lane, then read every lane back
    for (int w = 0; w < 40; w++)
      for (int l = 0; l < NFD; l++) axi_write(w, l, $urandom);
    for (int w = 0; w < 40; w++)
      for (int l = 0; l < NFD; l++) axi_read(w, l);
    axi_write(MD, 0, $urandom);
    axi_write(5, 3, $urandom);
    axi_read(5, 3);
    axi_read(MD, 1);
    axi_read(5, 0);

    // Restart streaming from a clean reset
    rst = 1;
    tick(2);
    load_expected();
    stream_chk = 1;
    tready = 2'b11;
    afull = 2'b00;
    rst = 0;
    first0 = -1;
    first1 = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tvalid[0] && first0 < 0) first0 = k;
      if (tvalid[1] && first1 < 0) first1 = k;
    end
    check("s0_first_tvalid", first0, 3);
    check("s1_first_tvalid", first1, 4);
    @(posedge clk);
    #1;
    tick(10);

    // Fairness: both streams at half rate
    b0 = beats0;
    b1 = beats1;
    tick(40);
    check("fair_s0_beats", beats0 - b0, 20);
    check("fair_s1_beats", beats1 - b1, 20);

    // A write during full-rate streaming must not disturb the rotation
    pop_log.delete();
    log_en = 1;
    tick(6);
    axi_write(50, 0, $urandom);
    tick(8);
    log_en = 0;
    reps = 0;
    for (int i = 1; i < pop_log.size(); i++)
      if (pop_log[i] == pop_log[i-1]) reps++;
    check("prio_rotation_repeats", reps, 0);

    // Random almost-full, then random ready
    for (int i = 0; i < 300; i++) begin
      afull = 2'($urandom);
      tick(1);
    end
    afull = 0;
    for (int i = 0; i < 200; i++) begin
      tready = 2'($urandom);
      tick(1);
    end

    // Backpressure on stream 1: stream 0 takes the whole port
    tready = 2'b01;
    tick(10);
    b0 = beats0;
    b1 = beats1;
    tick(40);
    check("bp_s0_full_rate", beats0 - b0, 40);
    check("bp_s1_no_beats", beats1 - b1, 0);
    @(negedge clk);
    check("bp_s1_buffered", tvalid[1], 1);
    @(posedge clk);
    #1;
    tready = 2'b11;
    tick(30);

    // Reset with words buffered: everything empties, replay restarts at offsets
    tready = 2'b00;
    tick(10);
    rst = 1;
    tick(1);
    rst = 0;
    load_expected();
    @(negedge clk);
    check("midrst_tvalid", tvalid, 0);
    @(posedge clk);
    #1;
    tready = 2'b11;
    tick(60);
    tready = 2'b00;
    tick(5);

    // Final readbacks, including the word written during streaming
    axi_read(50, 0);
    axi_read(5, 0);
    axi_read(5, 2);
    tick(5);
    check("b_queue_drained", bq.size(), 0);
    check("r_queue_drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
